// File: rtl/cl_axil_regfile_pkg.sv
// Shared types, register offsets and byte-strobe merge for the CL AXI-Lite register file.
package cl_axil_regfile_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  localparam int unsigned ID_OFF       = 32'h00;
  localparam int unsigned VLED_OFF     = 32'h04;
  localparam int unsigned VDIP_OFF     = 32'h08;
  localparam int unsigned CYCLE_OFF    = 32'h0C;
  localparam int unsigned SCRATCH_BASE = 32'h10;

  typedef enum logic [1:0] {
    WR_IDLE    = 2'd0,
    WR_HAVE_AW = 2'd1,
    WR_HAVE_W  = 2'd2,
    WR_RESP    = 2'd3
  } wr_state_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_t;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old,
                                              input logic [31:0] data,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/cl_rst_sync.sv
// Reset synchroniser: asserts asynchronously, releases after two clock edges.
module cl_rst_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  output logic rst_n_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) sync_q <= 2'b00;
    else          sync_q <= {sync_q[0], 1'b1};
  end

  assign rst_n_o = sync_q[1];

endmodule

// File: rtl/cl_axil_regfile.sv
// AXI4-Lite register file for the OCL BAR0 slice: ID, VLED, VDIP, free-running
// cycle counter and a bank of byte-writable scratch registers.
module cl_axil_regfile
  import cl_axil_regfile_pkg::*;
#(
  parameter int          ADDR_W      = 32,
  parameter int          NUM_SCRATCH = 8,
  parameter logic [31:0] ID_VALUE    = 32'hC0DE_0001,
  parameter logic [15:0] VLED_RST    = 16'h0000
) (
  input  logic              clk_main_a0,
  input  logic              rst_main_n,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  output logic [1:0]        s_axi_bresp,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  input  logic [15:0]       sh_cl_status_vdip,
  output logic [15:0]       cl_sh_status_vled
);

  localparam int IW = ADDR_W - 2;
  localparam logic [IW-1:0] ID_IDX    = IW'(ID_OFF >> 2);
  localparam logic [IW-1:0] VLED_IDX  = IW'(VLED_OFF >> 2);
  localparam logic [IW-1:0] VDIP_IDX  = IW'(VDIP_OFF >> 2);
  localparam logic [IW-1:0] CYCLE_IDX = IW'(CYCLE_OFF >> 2);
  localparam logic [IW-1:0] SCR_IDX   = IW'(SCRATCH_BASE >> 2);

  logic                   rst_n;
  logic                   rdy_en_q;
  wr_state_t              wr_state_q, wr_state_d;
  rd_state_t              rd_state_q, rd_state_d;
  logic [ADDR_W-1:0]      aw_addr_q;
  logic [31:0]            w_data_q;
  logic [3:0]             w_strb_q;
  resp_t                  bresp_q, rresp_q;
  logic [31:0]            rdata_q;
  logic [15:0]            vled_q;
  logic [31:0]            scratch_q [NUM_SCRATCH];
  logic [31:0]            cycle_q;
  logic [15:0]            vdip_meta_q, vdip_q;

  logic                   aw_hs, w_hs, ar_hs;
  logic                   wr_commit;
  logic [ADDR_W-1:0]      wr_addr_c;
  logic [31:0]            wr_data_c;
  logic [3:0]             wr_strb_c;
  logic [IW-1:0]          wr_idx, rd_idx;
  logic                   wr_vled;
  logic [NUM_SCRATCH-1:0] wr_scr_hit;
  resp_t                  wr_resp_c, rd_resp_c;
  logic [31:0]            rd_data_c;
  logic [31:0]            vled_wr_c;
  logic                   unused_bits;

  cl_rst_sync u_rst_sync (
    .clk_i   (clk_main_a0),
    .rst_n_i (rst_main_n),
    .rst_n_o (rst_n)
  );

  assign s_axi_awready     = rdy_en_q & ((wr_state_q == WR_IDLE) | (wr_state_q == WR_HAVE_W));
  assign s_axi_wready      = rdy_en_q & ((wr_state_q == WR_IDLE) | (wr_state_q == WR_HAVE_AW));
  assign s_axi_bvalid      = (wr_state_q == WR_RESP);
  assign s_axi_bresp       = bresp_q;
  assign s_axi_arready     = rdy_en_q & (rd_state_q == RD_IDLE);
  assign s_axi_rvalid      = (rd_state_q == RD_DATA);
  assign s_axi_rdata       = rdata_q;
  assign s_axi_rresp       = rresp_q;
  assign cl_sh_status_vled = vled_q;

  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid & s_axi_wready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;

  // The commit source picks up whichever half was latched earlier.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_commit  = 1'b0;
    wr_addr_c  = s_axi_awaddr;
    wr_data_c  = s_axi_wdata;
    wr_strb_c  = s_axi_wstrb;
    case (wr_state_q)
      WR_IDLE: begin
        if (aw_hs && w_hs) begin
          wr_commit  = 1'b1;
          wr_state_d = WR_RESP;
        end else if (aw_hs) begin
          wr_state_d = WR_HAVE_AW;
        end else if (w_hs) begin
          wr_state_d = WR_HAVE_W;
        end
      end
      WR_HAVE_AW: begin
        wr_addr_c = aw_addr_q;
        if (w_hs) begin
          wr_commit  = 1'b1;
          wr_state_d = WR_RESP;
        end
      end
      WR_HAVE_W: begin
        wr_data_c = w_data_q;
        wr_strb_c = w_strb_q;
        if (aw_hs) begin
          wr_commit  = 1'b1;
          wr_state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (s_axi_bvalid && s_axi_bready) wr_state_d = WR_IDLE;
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_comb begin
    wr_idx     = wr_addr_c[ADDR_W-1:2];
    wr_vled    = 1'b0;
    wr_scr_hit = '0;
    wr_resp_c  = DECERR;
    if (wr_idx == ID_IDX || wr_idx == VDIP_IDX || wr_idx == CYCLE_IDX) begin
      wr_resp_c = SLVERR;
    end else if (wr_idx == VLED_IDX) begin
      wr_vled   = 1'b1;
      wr_resp_c = OKAY;
    end else begin
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (wr_idx == SCR_IDX + IW'(i)) begin
          wr_scr_hit[i] = 1'b1;
          wr_resp_c     = OKAY;
        end
      end
    end
    // An empty strobe touches nothing, so a read-only target is not an error.
    if (wr_strb_c == 4'b0000 && wr_resp_c == SLVERR) wr_resp_c = OKAY;
  end

  assign vled_wr_c = apply_wstrb({16'h0000, vled_q}, wr_data_c, {2'b00, wr_strb_c[1:0]});

  always_comb begin
    rd_idx    = s_axi_araddr[ADDR_W-1:2];
    rd_data_c = '0;
    rd_resp_c = DECERR;
    if (rd_idx == ID_IDX) begin
      rd_data_c = ID_VALUE;
      rd_resp_c = OKAY;
    end else if (rd_idx == VLED_IDX) begin
      rd_data_c = {16'h0000, vled_q};
      rd_resp_c = OKAY;
    end else if (rd_idx == VDIP_IDX) begin
      rd_data_c = {16'h0000, vdip_q};
      rd_resp_c = OKAY;
    end else if (rd_idx == CYCLE_IDX) begin
      rd_data_c = cycle_q;
      rd_resp_c = OKAY;
    end else begin
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (rd_idx == SCR_IDX + IW'(i)) begin
          rd_data_c = scratch_q[i];
          rd_resp_c = OKAY;
        end
      end
    end
  end

  assign rd_state_d = (rd_state_q == RD_IDLE) ? (ar_hs ? RD_DATA : RD_IDLE)
                                              : ((s_axi_rvalid && s_axi_rready) ? RD_IDLE : RD_DATA);

  // Control and response registers
  always_ff @(posedge clk_main_a0 or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q   <= 1'b0;
      wr_state_q <= WR_IDLE;
      rd_state_q <= RD_IDLE;
      bresp_q    <= OKAY;
      rresp_q    <= OKAY;
      rdata_q    <= '0;
    end else begin
      rdy_en_q   <= 1'b1;
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      if (wr_commit) bresp_q <= wr_resp_c;
      if (ar_hs) begin
        rdata_q <= rd_data_c;
        rresp_q <= rd_resp_c;
      end
    end
  end

  // Architectural registers; reads sampled on the same edge see the old value
  always_ff @(posedge clk_main_a0 or negedge rst_n) begin
    if (!rst_n) begin
      vled_q  <= VLED_RST;
      cycle_q <= '0;
      for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (wr_commit && wr_vled) vled_q <= vled_wr_c[15:0];
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (wr_commit && wr_scr_hit[i]) scratch_q[i] <= apply_wstrb(scratch_q[i], wr_data_c, wr_strb_c);
      end
    end
  end

  // Half-transaction holding registers and DIP synchroniser
  always_ff @(posedge clk_main_a0) begin
    if (wr_state_q == WR_IDLE && aw_hs && !w_hs) aw_addr_q <= s_axi_awaddr;
    if (wr_state_q == WR_IDLE && w_hs && !aw_hs) begin
      w_data_q <= s_axi_wdata;
      w_strb_q <= s_axi_wstrb;
    end
    vdip_meta_q <= sh_cl_status_vdip;
    vdip_q      <= vdip_meta_q;
  end

  assign unused_bits = &{1'b0, wr_addr_c[1:0], s_axi_araddr[1:0], vled_wr_c[31:16]};

endmodule

// File: tb/tb_cl_axil_regfile.sv
// Scoreboard bench for cl_axil_regfile: tasks drive AXI-Lite traffic and push
// expected responses; a negedge monitor pops and compares at each B/R handshake.
`timescale 1ns/1ps
module tb_cl_axil_regfile;
  localparam int          ADDR_W = 32;
  localparam logic [31:0] IDV    = 32'hC0DE_0001;
  localparam logic [15:0] VRST   = 16'h0000;
  localparam logic [15:0] DIP    = 16'h5A3C;
  localparam logic [1:0]  R_OK   = 2'b00;
  localparam logic [1:0]  R_SLV  = 2'b10;
  localparam logic [1:0]  R_DEC  = 2'b11;

  logic              clk_main_a0 = 1'b0;
  logic              rst_main_n  = 1'b0;
  logic              s_axi_awvalid = 1'b0, s_axi_awready;
  logic [ADDR_W-1:0] s_axi_awaddr = '0;
  logic              s_axi_wvalid = 1'b0, s_axi_wready;
  logic [31:0]       s_axi_wdata = '0;
  logic [3:0]        s_axi_wstrb = '0;
  logic              s_axi_bvalid, s_axi_bready = 1'b0;
  logic [1:0]        s_axi_bresp;
  logic              s_axi_arvalid = 1'b0, s_axi_arready;
  logic [ADDR_W-1:0] s_axi_araddr = '0;
  logic              s_axi_rvalid, s_axi_rready = 1'b0;
  logic [31:0]       s_axi_rdata;
  logic [1:0]        s_axi_rresp;
  logic [15:0]       sh_cl_status_vdip = DIP;
  logic [15:0]       cl_sh_status_vled;

  cl_axil_regfile dut (
    .clk_main_a0(clk_main_a0), .rst_main_n(rst_main_n),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_bresp(s_axi_bresp), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_araddr(s_axi_araddr), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .sh_cl_status_vdip(sh_cl_status_vdip), .cl_sh_status_vled(cl_sh_status_vled)
  );

  always #5 clk_main_a0 = ~clk_main_a0;

  typedef struct packed { logic chk; logic [31:0] d; logic [1:0] r; } rexp_t;
  logic [1:0]  exp_b_q [$];
  rexp_t       exp_r_q [$];
  int          vectors = 0;
  int          miscompares = 0;
  int unsigned tb_cyc = 0;
  int unsigned ar_cyc = 0;
  logic [31:0] last_rdata = '0;
  logic [1:0]  eb;
  rexp_t       er;

  always @(posedge clk_main_a0) tb_cyc <= tb_cyc + 1;

  always @(negedge clk_main_a0) begin
    if (rst_main_n && s_axi_bvalid && s_axi_bready) begin
      vectors++;
      if (exp_b_q.size() == 0) begin
        miscompares++;
        $display("FAIL bresp_extra got %b want no response", s_axi_bresp);
      end else begin
        eb = exp_b_q.pop_front();
        if (s_axi_bresp !== eb) begin
          miscompares++;
          $display("FAIL bresp got %b want %b", s_axi_bresp, eb);
        end
      end
    end
    if (rst_main_n && s_axi_rvalid && s_axi_rready) begin
      last_rdata = s_axi_rdata;
      if (exp_r_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rdata_extra got %h want no response", s_axi_rdata);
      end else begin
        er = exp_r_q.pop_front();
        if (er.chk) begin
          vectors++;
          if (s_axi_rdata !== er.d || s_axi_rresp !== er.r) begin
            miscompares++;
            $display("FAIL rdata got %h/%b want %h/%b", s_axi_rdata, s_axi_rresp, er.d, er.r);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog sim time exceeded, got no finish want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_main_a0);
    #1;
  endtask

  task automatic do_aw(input logic [31:0] a);
    int n = 0;
    s_axi_awaddr = a; s_axi_awvalid = 1'b1;
    while (!s_axi_awready && n < 20) begin tick(); n++; end
    if (!s_axi_awready) begin vectors++; miscompares++; $display("FAIL aw_timeout awready=%b want 1", s_axi_awready); end
    tick();
    s_axi_awvalid = 1'b0;
  endtask

  task automatic do_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
    while (!s_axi_wready && n < 20) begin tick(); n++; end
    if (!s_axi_wready) begin vectors++; miscompares++; $display("FAIL w_timeout wready=%b want 1", s_axi_wready); end
    tick();
    s_axi_wvalid = 1'b0;
  endtask

  task automatic do_ar(input logic [31:0] a);
    int n = 0;
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    while (!s_axi_arready && n < 20) begin tick(); n++; end
    if (!s_axi_arready) begin vectors++; miscompares++; $display("FAIL ar_timeout arready=%b want 1", s_axi_arready); end
    tick();
    ar_cyc = tb_cyc;
    s_axi_arvalid = 1'b0;
  endtask

  task automatic collect_b();
    int n = 0;
    while (!s_axi_bvalid && n < 20) begin tick(); n++; end
    if (!s_axi_bvalid) begin vectors++; miscompares++; $display("FAIL b_timeout bvalid=%b want 1", s_axi_bvalid); end
    s_axi_bready = 1'b1; tick(); s_axi_bready = 1'b0;
  endtask

  task automatic collect_r();
    int n = 0;
    while (!s_axi_rvalid && n < 20) begin tick(); n++; end
    if (!s_axi_rvalid) begin vectors++; miscompares++; $display("FAIL r_timeout rvalid=%b want 1", s_axi_rvalid); end
    s_axi_rready = 1'b1; tick(); s_axi_rready = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] r);
    int n = 0;
    exp_b_q.push_back(r);
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    while (!(s_axi_awready && s_axi_wready) && n < 20) begin tick(); n++; end
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    collect_b();
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r, input logic chk);
    exp_r_q.push_back('{chk: chk, d: d, r: r});
    do_ar(a);
    collect_r();
  endtask

  task automatic wait_ready_after_reset();
    int n = 0;
    while (!(s_axi_awready && s_axi_wready && s_axi_arready) && n < 10) begin tick(); n++; end
    vectors++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
      miscompares++;
      $display("FAIL ready_after_reset got %b want 111", {s_axi_awready, s_axi_wready, s_axi_arready});
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    vectors++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, s_axi_bresp, s_axi_rresp} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got %b want 0", {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, s_axi_bresp, s_axi_rresp});
    end
    vectors++;
    if (s_axi_rdata !== 32'h0 || cl_sh_status_vled !== VRST) begin
      miscompares++;
      $display("FAIL reset_data got rdata=%h vled=%h want 0/%h", s_axi_rdata, cl_sh_status_vled, VRST);
    end
    rst_main_n = 1'b1;
    wait_ready_after_reset();
  endtask

  task automatic test_read_basic();
    exp_r_q.push_back('{chk: 1'b1, d: IDV, r: R_OK});
    do_ar(32'h00);
    vectors++;
    if (s_axi_rvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL read_latency rvalid=%b want 1 one cycle after AR", s_axi_rvalid);
    end
    collect_r();
    rd(32'h04, 32'h0, R_OK, 1'b1);
    vectors++;
    if (cl_sh_status_vled !== VRST) begin miscompares++; $display("FAIL vled_init got %h want %h", cl_sh_status_vled, VRST); end
    rd(32'h08, {16'h0, DIP}, R_OK, 1'b1);
  endtask

  task automatic test_write_split();
    exp_b_q.push_back(R_OK);
    do_aw(32'h04);
    vectors++;
    if ({s_axi_awready, s_axi_wready, s_axi_bvalid} !== 3'b010) begin
      miscompares++;
      $display("FAIL have_aw_ready got %b want 010", {s_axi_awready, s_axi_wready, s_axi_bvalid});
    end
    tick(); tick();
    do_w(32'h0000_A5A5, 4'b0011);
    vectors++;
    if (s_axi_bvalid !== 1'b1) begin miscompares++; $display("FAIL bvalid_latency got %b want 1", s_axi_bvalid); end
    collect_b();
    vectors++;
    if (cl_sh_status_vled !== 16'hA5A5) begin miscompares++; $display("FAIL vled_aw_first got %h want a5a5", cl_sh_status_vled); end

    exp_b_q.push_back(R_OK);
    do_w(32'h0000_5A5A, 4'b0011);
    vectors++;
    if ({s_axi_awready, s_axi_wready} !== 2'b10) begin
      miscompares++;
      $display("FAIL have_w_ready got %b want 10", {s_axi_awready, s_axi_wready});
    end
    tick(); tick();
    do_aw(32'h04);
    vectors++;
    if (s_axi_bvalid !== 1'b1) begin miscompares++; $display("FAIL bvalid_w_first got %b want 1", s_axi_bvalid); end
    collect_b();
    vectors++;
    if (cl_sh_status_vled !== 16'h5A5A) begin miscompares++; $display("FAIL vled_w_first got %h want 5a5a", cl_sh_status_vled); end
    rd(32'h04, 32'h0000_5A5A, R_OK, 1'b1);
  endtask

  task automatic test_strobes();
    wr(32'h18, 32'h1122_3344, 4'b1111, R_OK);
    wr(32'h18, 32'hAABB_CCDD, 4'b0101, R_OK);
    rd(32'h18, 32'h11BB_33DD, R_OK, 1'b1);
    wr(32'h18, 32'hFFFF_FFFF, 4'b0000, R_OK);
    rd(32'h18, 32'h11BB_33DD, R_OK, 1'b1);
    rd(32'h1B, 32'h11BB_33DD, R_OK, 1'b1);
    wr(32'h04, 32'hFFFF_FFFF, 4'b1111, R_OK);
    rd(32'h04, 32'h0000_FFFF, R_OK, 1'b1);
    vectors++;
    if (cl_sh_status_vled !== 16'hFFFF) begin miscompares++; $display("FAIL vled_full got %h want ffff", cl_sh_status_vled); end
    wr(32'h2C, 32'h1234_5678, 4'b1111, R_OK);
    rd(32'h2C, 32'h1234_5678, R_OK, 1'b1);
  endtask

  task automatic test_errors();
    wr(32'h08, 32'hFFFF_0000, 4'b1111, R_SLV);
    rd(32'h08, {16'h0, DIP}, R_OK, 1'b1);
    wr(32'h00, 32'h0, 4'b1111, R_SLV);
    rd(32'h00, IDV, R_OK, 1'b1);
    wr(32'h30, 32'hDEAD_BEEF, 4'b1111, R_DEC);
    rd(32'h30, 32'h0, R_DEC, 1'b1);
    rd(32'h1000_0010, 32'h0, R_DEC, 1'b1);
  endtask

  task automatic test_backpressure();
    exp_b_q.push_back(R_OK);
    s_axi_awaddr = 32'h1C; s_axi_wdata = 32'hCAFE_F00D; s_axi_wstrb = 4'b1111;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    tick();
    s_axi_awaddr = 32'h20; s_axi_wdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({s_axi_bvalid, s_axi_bresp, s_axi_awready, s_axi_wready} !== 5'b10000) begin
        miscompares++;
        $display("FAIL b_hold cyc %0d got %b want 10000", i, {s_axi_bvalid, s_axi_bresp, s_axi_awready, s_axi_wready});
      end
      tick();
    end
    s_axi_bready = 1'b1; tick();
    s_axi_bready = 1'b0; s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    vectors++;
    if (s_axi_bvalid !== 1'b0) begin miscompares++; $display("FAIL b_second got bvalid=%b want 0", s_axi_bvalid); end
    rd(32'h20, 32'h0, R_OK, 1'b1);

    exp_r_q.push_back('{chk: 1'b1, d: 32'hCAFE_F00D, r: R_OK});
    do_ar(32'h1C);
    s_axi_araddr = 32'h00; s_axi_arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({s_axi_rvalid, s_axi_arready, s_axi_rresp, s_axi_rdata} !== {1'b1, 1'b0, R_OK, 32'hCAFE_F00D}) begin
        miscompares++;
        $display("FAIL r_hold cyc %0d got %b/%b/%b/%h want 1/0/00/cafef00d", i, s_axi_rvalid, s_axi_arready, s_axi_rresp, s_axi_rdata);
      end
      tick();
    end
    s_axi_rready = 1'b1; tick();
    s_axi_rready = 1'b0; s_axi_arvalid = 1'b0;
    vectors++;
    if (s_axi_rvalid !== 1'b0) begin miscompares++; $display("FAIL r_second got rvalid=%b want 0", s_axi_rvalid); end
  endtask

  task automatic test_concurrent();
    int n = 0;
    exp_b_q.push_back(R_OK);
    exp_r_q.push_back('{chk: 1'b1, d: 32'h0, r: R_OK});
    s_axi_awaddr = 32'h24; s_axi_wdata = 32'h0000_0001; s_axi_wstrb = 4'b1111;
    s_axi_araddr = 32'h24;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
    while (!(s_axi_awready && s_axi_wready && s_axi_arready) && n < 20) begin tick(); n++; end
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    collect_b();
    collect_r();
    rd(32'h24, 32'h0000_0001, R_OK, 1'b1);
  endtask

  task automatic test_cycle();
    logic [31:0] c1, c2, dd, dt;
    int unsigned t1, t2;
    rd(32'h0C, 32'h0, R_OK, 1'b0);
    c1 = last_rdata; t1 = ar_cyc;
    repeat (17) tick();
    rd(32'h0C, 32'h0, R_OK, 1'b0);
    c2 = last_rdata; t2 = ar_cyc;
    dd = c2 - c1;
    dt = t2 - t1;
    vectors++;
    if (dd !== dt) begin miscompares++; $display("FAIL cycle_delta got %0d want %0d", dd, dt); end
  endtask

  task automatic test_reset_midwrite();
    do_aw(32'h1C);
    vectors++;
    if ({s_axi_awready, s_axi_wready} !== 2'b01) begin
      miscompares++;
      $display("FAIL midwrite_state got %b want 01", {s_axi_awready, s_axi_wready});
    end
    #2;
    rst_main_n = 1'b0;
    #1;
    vectors++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, s_axi_rdata} !== 37'b0) begin
      miscompares++;
      $display("FAIL reset_immediate got %b/%h want 0/0", {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid}, s_axi_rdata);
    end
    vectors++;
    if (cl_sh_status_vled !== VRST) begin miscompares++; $display("FAIL reset_vled got %h want %h", cl_sh_status_vled, VRST); end
    s_axi_wdata = 32'hDEAD_BEEF; s_axi_wstrb = 4'b1111; s_axi_wvalid = 1'b1;
    repeat (3) tick();
    s_axi_wvalid = 1'b0;
    rst_main_n = 1'b1;
    wait_ready_after_reset();
    rd(32'h1C, 32'h0, R_OK, 1'b1);
    rd(32'h04, {16'h0, VRST}, R_OK, 1'b1);
    wr(32'h1C, 32'h600D_CAFE, 4'b1111, R_OK);
    rd(32'h1C, 32'h600D_CAFE, R_OK, 1'b1);
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_split();
    test_strobes();
    test_errors();
    test_backpressure();
    test_concurrent();
    test_cycle();
    test_reset_midwrite();
    tick(); tick();
    vectors++;
    if (exp_b_q.size() + exp_r_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover got %0d want 0", exp_b_q.size() + exp_r_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cl_axil_regfile.md
Name: cl_axil_regfile

Overview:
Parameterised AXI4-Lite slave register file behind the OCL BAR0 register slice, clocked on clk_main_a0. Generalises the single-register hello-world core:
- configurable count of scratch registers;
- independent AW/W acceptance;
- RO status registers including a free-running cycle counter;
- per-byte write strobes;
- SLVERR/DECERR responses.

Drives the virtual LEDs and samples the virtual DIP switches.

Parameters:
ADDR_W, 32, AXI-L address width.
NUM_SCRATCH, 8, number of RW scratch registers (1..64).
ID_VALUE, 32'hC0DE_0001, constant returned at offset 0x00.
VLED_RST, 16'h0000, reset value of the VLED register.

Ports:
clk_main_a0  in  1  clock
rst_main_n  in  1  reset, asynchronous, active-low
s_axi_awvalid/awready  in/out  1  write address handshake
s_axi_awaddr  in  ADDR_W  write byte address
s_axi_wvalid/wready  in/out  1  write data handshake
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte enables
s_axi_bvalid/bready  out/in  1  write response handshake
s_axi_bresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
s_axi_arvalid/arready  in/out  1  read address handshake
s_axi_araddr  in  ADDR_W  read byte address
s_axi_rvalid/rready  out/in  1  read data handshake
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  read response
sh_cl_status_vdip  in  16  virtual DIP switches (async to logic, 2-flop synced)
cl_sh_status_vled  out  16  virtual LEDs

Behaviour:
Reset:
- rst_main_n asserts asynchronously and deasserts through a 2-flop synchroniser.
- All valid/ready outputs are 0 during reset; all resp outputs are 00; rdata = 0.
- VLED = VLED_RST, scratch registers = 0, cycle counter = 0.
- Ready outputs rise on the first cycle after synchronised release.

Address decode:
- Bits [1:0] are ignored; word index = addr[ADDR_W-1:2].
- Register map:
  - 0x00 ID (RO)
  - 0x04 VLED (RW, bits 15:0; bits 31:16 read 0)
  - 0x08 VDIP (RO, synced)
  - 0x0C CYCLE (RO, 32-bit free-running, wraps FFFF_FFFF -> 0)
  - 0x10 + 4*i SCRATCH[i] for i < NUM_SCRATCH (RW)
- Any other index is unmapped.

Write FSM (states WR_IDLE, WR_HAVE_AW, WR_HAVE_W, WR_RESP):
- WR_IDLE: awready = wready = 1.
  - AW and W in the same cycle -> write committed that clock edge -> WR_RESP.
  - AW only -> latch addr -> WR_HAVE_AW (awready = 0, wready = 1).
  - W only -> latch data/strb -> WR_HAVE_W.
- WR_HAVE_AW / WR_HAVE_W: commit on arrival of the missing half -> WR_RESP.
- WR_RESP: bvalid = 1 from the cycle after commit, held until bready; awready = wready = 0; return to WR_IDLE on bvalid & bready.
- Write commit: byte lanes update per wstrb. VLED updates only lanes 0-1.
  - wstrb = 0 -> no change, OKAY.
  - Write to RO register -> no change, SLVERR.
  - Write to unmapped address -> DECERR.

Read FSM (states RD_IDLE, RD_DATA):
- RD_IDLE: arready = 1. On AR handshake, register rdata/rresp -> RD_DATA.
- RD_DATA: rvalid = 1 (one cycle after AR) with rdata/rresp held stable until rready; arready = 0.
- Unmapped address -> rdata = 0, DECERR.
- CYCLE read returns the counter value sampled at the AR handshake edge.

Concurrency:
- Read and write channels are fully independent.
- Same-cycle write commit and read capture to the same register: read returns the pre-write value.

Outputs:
- cl_sh_status_vled = VLED register, registered output.

Decomposition:
- Package cl_axil_regfile_pkg holds:
  - resp_t enum (OKAY, SLVERR, DECERR);
  - register offset localparams (ID_OFF, VLED_OFF, VDIP_OFF, CYCLE_OFF, SCRATCH_BASE);
  - wr_state_t and rd_state_t enums;
  - function apply_wstrb(old, data, strb).
- One sub-module, cl_rst_sync: the 2-flop async-assert/sync-release reset synchroniser, reusable across CL examples.
- The decode and FSMs stay inline.

Test Plan:
1. Reset release, then read 0x00 -> rvalid exactly 1 cycle after AR handshake, rdata = ID_VALUE, rresp = 00. Read 0x04 -> 0000_0000; vled = 0000.
2. AW at cycle 0, W at cycle 3 to 0x04, data 0000_A5A5, strb 0011 -> bvalid at cycle 4, OKAY; vled = A5A5. W-before-AW ordering gives the same result.
3. SCRATCH[2] preset to 1122_3344; write 0x18, data AABB_CCDD, strb 0101 -> read back 11BB_33DD.
4. Write 0x08 -> SLVERR, VDIP unchanged. Write or read at 0x10 + 4*NUM_SCRATCH -> DECERR, rdata = 0.
5. Hold bready = 0 and rready = 0 for 5 cycles -> bvalid/rvalid, resp and rdata stay stable; awready/arready stay 0 and no second transaction is accepted.
6. Read CYCLE twice, N cycles apart -> difference = N. Pulse rst_main_n low mid-write (in WR_HAVE_AW) -> all outputs clear immediately and no register changes; a subsequent clean write succeeds.
